gsim_sweep_ctrl: RTL and testbench

//  Sequencer for the GSIM Gauss-Seidel solver (16 unknowns, banded matrix 20/-13/6/-1).
//  - Captures the 16-sample b vector and clears the x state.
//  - Runs ITER_NUM in-place update sweeps over x[0..N-1] through the shared update datapath.
//  - Drains x as 16 consecutive out_valid beats (16.16 fixed point, carried on the datapath x_out).
//  - Sits between the GSIM top ports (in_en, out_valid) and the datapath / x register file.

---
 rtl/gsim_pkg.sv | 22 ++
 rtl/gsim_nb_mask.sv | 21 ++
 rtl/gsim_sweep_ctrl.sv | 118 +++++++++++
 tb/tb_gsim_sweep_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gsim_pkg.sv
// Shared constants for the GSIM Gauss-Seidel solver.
// Sizes, band coefficients, fixed-point format and sequencer states.
package gsim_pkg;

    localparam int N      = 16;
    localparam int IDX_W  = 4;
    localparam int NB_W   = 6;
    localparam int FRAC_W = 16;

    localparam int signed COEF_D = 20;
    localparam int signed COEF_1 = -13;
    localparam int signed COEF_2 = 6;
    localparam int signed COEF_3 = -1;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_LOAD  = 2'd1;
    localparam state_t ST_SWEEP = 2'd2;
    localparam state_t ST_DRAIN = 2'd3;

endpackage

// File: rtl/gsim_nb_mask.sv
// Neighbour-present mask for a row of the banded matrix.
// Bit order: i-3, i-2, i-1, i+1, i+2, i+3.
module gsim_nb_mask
    import gsim_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    output logic [NB_W-1:0]  mask
);

    // Each neighbour exists only if its index stays inside 0..N-1
    always_comb begin
        mask    = '0;
        mask[0] = idx >= IDX_W'(3);
        mask[1] = idx >= IDX_W'(2);
        mask[2] = idx >= IDX_W'(1);
        mask[3] = idx <= IDX_W'(N - 2);
        mask[4] = idx <= IDX_W'(N - 3);
        mask[5] = idx <= IDX_W'(N - 4);
    end

endmodule

// File: rtl/gsim_sweep_ctrl.sv
// GSIM sequencer: load b, run ITER_NUM Gauss-Seidel sweeps,
// then drain x as N output beats.
module gsim_sweep_ctrl
    import gsim_pkg::*;
#(
    parameter int ITER_NUM = 64,
    parameter int IT_W     = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_en,
    output logic             b_wr_en,
    output logic [IDX_W-1:0] b_wr_addr,
    output logic             x_clr,
    output logic             upd_req,
    output logic [IDX_W-1:0] upd_idx,
    output logic [NB_W-1:0]  nb_mask,
    input  logic             upd_done,
    output logic [IDX_W-1:0] x_rd_addr,
    output logic             out_valid,
    output logic             busy,
    output logic [IT_W-1:0]  iter_cnt
);

    localparam int DW = IDX_W + 1;

    state_t           state;
    logic [IDX_W-1:0] ld_cnt;
    logic [DW-1:0]    drn_cnt;
    logic [NB_W-1:0]  mask_raw;
    logic             upd_acc;
    logic             last_idx;
    logic             last_it;
    logic             drn_rd;

    gsim_nb_mask u_nb_mask (
        .idx  (upd_idx),
        .mask (mask_raw)
    );

    assign upd_acc  = upd_req & upd_done;
    assign last_idx = upd_idx == IDX_W'(N - 1);
    assign last_it  = iter_cnt == IT_W'(ITER_NUM - 1);
    assign drn_rd   = (state == ST_DRAIN) && !drn_cnt[IDX_W];

    // Port-side strobes are decoded straight from state and in_en
    always_comb begin
        b_wr_en   = in_en && (state == ST_IDLE || state == ST_LOAD);
        b_wr_addr = ld_cnt;
        x_clr     = in_en && (state == ST_IDLE);
        busy      = state != ST_IDLE;
        x_rd_addr = drn_rd ? drn_cnt[IDX_W-1:0] : '0;
        nb_mask   = upd_req ? mask_raw : '0;
    end

    // Sequencer FSM with load, sweep and drain counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ld_cnt    <= '0;
            drn_cnt   <= '0;
            upd_req   <= 1'b0;
            upd_idx   <= '0;
            iter_cnt  <= '0;
            out_valid <= 1'b0;
        end else begin
            // x read data arrives one cycle after its address
            out_valid <= drn_rd;
            unique case (state)
                ST_IDLE: begin
                    if (in_en) begin
                        ld_cnt <= IDX_W'(1);
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (in_en) begin
                        if (ld_cnt == IDX_W'(N - 1)) begin
                            ld_cnt   <= '0;
                            upd_req  <= 1'b1;
                            upd_idx  <= '0;
                            iter_cnt <= '0;
                            state    <= ST_SWEEP;
                        end else begin
                            ld_cnt <= ld_cnt + IDX_W'(1);
                        end
                    end
                end
                ST_SWEEP: begin
                    if (upd_acc) begin
                        if (!last_idx) begin
                            upd_idx <= upd_idx + IDX_W'(1);
                        end else if (!last_it) begin
                            upd_idx  <= '0;
                            iter_cnt <= iter_cnt + IT_W'(1);
                        end else begin
                            upd_req  <= 1'b0;
                            upd_idx  <= '0;
                            iter_cnt <= '0;
                            drn_cnt  <= '0;
                            state    <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drn_cnt[IDX_W]) begin
                        drn_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        drn_cnt <= drn_cnt + DW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gsim_sweep_ctrl.sv
// Directed bench for gsim_sweep_ctrl with ITER_NUM=2.
// A per-test datapath model answers upd_req after latency L.
module tb_gsim_sweep_ctrl;

    logic       clk;
    logic       reset;
    logic       in_en;
    logic       b_wr_en;
    logic [3:0] b_wr_addr;
    logic       x_clr;
    logic       upd_req;
    logic [3:0] upd_idx;
    logic [5:0] nb_mask;
    logic       upd_done;
    logic [3:0] x_rd_addr;
    logic       out_valid;
    logic       busy;
    logic [0:0] iter_cnt;
    logic [23:0] outs;

    int checks = 0;
    int failures = 0;

    localparam logic [5:0] MASKS [16] = '{
        6'b111000, 6'b111100, 6'b111110, 6'b111111,
        6'b111111, 6'b111111, 6'b111111, 6'b111111,
        6'b111111, 6'b111111, 6'b111111, 6'b111111,
        6'b111111, 6'b011111, 6'b001111, 6'b000111
    };

    gsim_sweep_ctrl #(
        .ITER_NUM (2),
        .IT_W     (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_en     (in_en),
        .b_wr_en   (b_wr_en),
        .b_wr_addr (b_wr_addr),
        .x_clr     (x_clr),
        .upd_req   (upd_req),
        .upd_idx   (upd_idx),
        .nb_mask   (nb_mask),
        .upd_done  (upd_done),
        .x_rd_addr (x_rd_addr),
        .out_valid (out_valid),
        .busy      (busy),
        .iter_cnt  (iter_cnt)
    );

    assign outs = {b_wr_en, b_wr_addr, x_clr, upd_req, upd_idx,
                   nb_mask, x_rd_addr, out_valid, busy, iter_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic en);
        @(negedge clk);
        in_en = en;
        upd_done = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        in_en = 1'b0;
        upd_done = 1'b0;
        step(1'b0);
        step(1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== 24'h0) begin
            failures++;
            $display("FAIL reset_outs got=%h exp=0", outs);
        end
        step(1'b0);
        checks++;
        if (outs !== 24'h0) begin
            failures++;
            $display("FAIL idle_outs got=%h exp=0", outs);
        end
    endtask

    task automatic test_load(input int gap);
        logic [3:0] ea;
        for (int s = 0; s < 16; s++) begin
            if (s == 8) begin
                for (int g = 0; g < gap; g++) begin
                    step(1'b0);
                    checks++;
                    if ({b_wr_en, x_clr, b_wr_addr, busy} !== {2'b00, 4'd8, 1'b1}) begin
                        failures++;
                        $display("FAIL load_gap got=%b%b a=%0d busy=%b exp=00 a=8 busy=1",
                                 b_wr_en, x_clr, b_wr_addr, busy);
                    end
                end
            end
            step(1'b1);
            ea = 4'(s);
            checks++;
            if (b_wr_en !== 1'b1 || b_wr_addr !== ea) begin
                failures++;
                $display("FAIL load_wr s=%0d got en=%b a=%0d exp en=1 a=%0d",
                         s, b_wr_en, b_wr_addr, ea);
            end
            checks++;
            if (x_clr !== (s == 0) || busy !== (s != 0) || upd_req !== 1'b0) begin
                failures++;
                $display("FAIL load_ctl s=%0d got clr=%b busy=%b req=%b exp clr=%b busy=%b req=0",
                         s, x_clr, busy, upd_req, s == 0, s != 0);
            end
        end
        step(1'b0);
        checks++;
        if ({upd_req, upd_idx, iter_cnt, busy, b_wr_en} !== {1'b1, 4'd0, 1'b0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL sweep_start got req=%b idx=%0d it=%0d busy=%b wr=%b exp 1 0 0 1 0",
                     upd_req, upd_idx, iter_cnt, busy, b_wr_en);
        end
    endtask

    task automatic run_sweep(input int lat, input bit tog, input int stop_tx,
                             output int ntx, output int nreq, output bit stopped);
        int w;
        bit pend;
        bit fin;
        logic [3:0] pidx;
        logic [5:0] pm;
        logic [3:0] ei;
        logic [0:0] eit;
        w = 0;
        pend = 0;
        fin = 0;
        ntx = 0;
        nreq = 0;
        stopped = 0;
        pidx = '0;
        pm = '0;
        for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
            if (cyc > 0) begin
                @(negedge clk);
                in_en = tog ? cyc[0] : 1'b0;
                upd_done = 1'b0;
                #1;
            end
            if (tog) begin
                checks++;
                if (b_wr_en !== 1'b0) begin
                    failures++;
                    $display("FAIL sweep_wr_en got=%b exp=0", b_wr_en);
                end
            end
            if (!upd_req) begin
                fin = 1;
            end else begin
                nreq++;
                if (pend) begin
                    checks++;
                    if (upd_idx !== pidx || nb_mask !== pm) begin
                        failures++;
                        $display("FAIL hold_stable got idx=%0d m=%b exp idx=%0d m=%b",
                                 upd_idx, nb_mask, pidx, pm);
                    end
                end else begin
                    ei = 4'(ntx % 16);
                    eit = 1'(ntx / 16);
                    checks++;
                    if (upd_idx !== ei || iter_cnt !== eit) begin
                        failures++;
                        $display("FAIL tx_order tx=%0d got idx=%0d it=%0d exp idx=%0d it=%0d",
                                 ntx, upd_idx, iter_cnt, ei, eit);
                    end
                    checks++;
                    if (nb_mask !== MASKS[ntx % 16]) begin
                        failures++;
                        $display("FAIL nb_mask idx=%0d got=%b exp=%b",
                                 ei, nb_mask, MASKS[ntx % 16]);
                    end
                    if (stop_tx >= 0 && ntx == stop_tx) begin
                        stopped = 1;
                        fin = 1;
                    end
                end
                if (!fin) begin
                    pidx = upd_idx;
                    pm = nb_mask;
                    if (w == lat) begin
                        upd_done = 1'b1;
                        w = 0;
                        pend = 0;
                        ntx++;
                    end else begin
                        w++;
                        pend = 1;
                    end
                end
            end
        end
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL sweep_timeout got tx=%0d exp=done", ntx);
        end
    endtask

    task automatic test_sweep_l3;
        int ntx;
        int nreq;
        bit st;
        run_sweep(3, 1'b0, -1, ntx, nreq, st);
        checks++;
        if (ntx !== 32) begin
            failures++;
            $display("FAIL l3_tx_count got=%0d exp=32", ntx);
        end
        checks++;
        if (nreq !== 128) begin
            failures++;
            $display("FAIL l3_req_cycles got=%0d exp=128", nreq);
        end
    endtask

    task automatic test_drain;
        int beats;
        logic [3:0] ea;
        beats = 0;
        for (int k = 0; k < 18; k++) begin
            if (k > 0) step(1'b0);
            ea = (k < 16) ? 4'(k) : 4'd0;
            checks++;
            if (x_rd_addr !== ea) begin
                failures++;
                $display("FAIL drain_addr k=%0d got=%0d exp=%0d", k, x_rd_addr, ea);
            end
            checks++;
            if (out_valid !== (k >= 1 && k <= 16) || busy !== (k <= 16)) begin
                failures++;
                $display("FAIL drain_ctl k=%0d got ov=%b busy=%b exp ov=%b busy=%b",
                         k, out_valid, busy, k >= 1 && k <= 16, k <= 16);
            end
            checks++;
            if (upd_req !== 1'b0 || b_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL drain_quiet k=%0d got req=%b wr=%b exp 0 0",
                         k, upd_req, b_wr_en);
            end
            if (out_valid === 1'b1) beats++;
        end
        checks++;
        if (beats !== 16) begin
            failures++;
            $display("FAIL drain_beats got=%0d exp=16", beats);
        end
    endtask

    task automatic test_back_to_back;
        int ntx;
        int nreq;
        bit st;
        test_load(0);
        run_sweep(0, 1'b0, -1, ntx, nreq, st);
        checks++;
        if (ntx !== 32 || nreq !== 32) begin
            failures++;
            $display("FAIL l0_rate got tx=%0d reqcyc=%0d exp 32 32", ntx, nreq);
        end
        test_drain();
    endtask

    task automatic test_reset_mid;
        int ntx;
        int nreq;
        bit st;
        test_load(0);
        run_sweep(0, 1'b0, 7, ntx, nreq, st);
        checks++;
        if (st !== 1'b1 || upd_idx !== 4'd7) begin
            failures++;
            $display("FAIL mid_reach got stop=%b idx=%0d exp stop=1 idx=7", st, upd_idx);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (outs !== 24'h0) begin
            failures++;
            $display("FAIL mid_reset_outs got=%h exp=0", outs);
        end
        test_load(0);
        test_sweep_l3();
        test_drain();
    endtask

    task automatic test_gap_toggle;
        int ntx;
        int nreq;
        bit st;
        test_load(5);
        run_sweep(3, 1'b1, -1, ntx, nreq, st);
        checks++;
        if (ntx !== 32) begin
            failures++;
            $display("FAIL toggle_tx_count got=%0d exp=32", ntx);
        end
        test_drain();
    endtask

    initial begin
        reset = 1'b1;
        in_en = 1'b0;
        upd_done = 1'b0;
        test_reset();
        test_load(0);
        test_sweep_l3();
        test_drain();
        test_back_to_back();
        test_reset_mid();
        test_gap_toggle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
